// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, result classes, canonical NaN and decode helpers.
// Used by the writeback stage to classify and sanitise FPU results.
package fpu_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] F_ALU_OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] F_ALU_OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] F_ALU_OP_MUL = 5'd2;
    localparam logic [OP_W-1:0] F_ALU_OP_MIN = 5'd3;
    localparam logic [OP_W-1:0] F_ALU_OP_MAX = 5'd4;
    localparam logic [OP_W-1:0] F_ALU_OP_EQ  = 5'd5;
    localparam logic [OP_W-1:0] F_ALU_OP_LT  = 5'd6;
    localparam logic [OP_W-1:0] F_ALU_OP_LE  = 5'd7;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_FP      = 2'd0,
        CLS_INT     = 2'd1,
        CLS_ILLEGAL = 2'd2
    } op_cls_e;

    function automatic op_cls_e decode_cls(input logic [OP_W-1:0] op);
        if (op <= F_ALU_OP_MAX) return CLS_FP;
        if (op <= F_ALU_OP_LE)  return CLS_INT;
        return CLS_ILLEGAL;
    endfunction

    // Arithmetic ops produce NaNs with arbitrary payloads; MIN/MAX forward operands verbatim.
    function automatic logic needs_canon(input logic [OP_W-1:0] op);
        return op <= F_ALU_OP_MUL;
    endfunction

    function automatic logic is_nan32(input logic [31:0] v);
        return (&v[30:23]) && (|v[22:0]);
    endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic DEPTH-entry valid/ready queue with synchronous flush; exposes every slot for hazard scans.
// Latency: pushed data is at the head the cycle after the push; push accepted when not full or popping.
module fpu_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      push_vld,
    output logic                      push_rdy,
    input  logic [W-1:0]              push_dat,
    output logic                      head_vld,
    output logic [AW-1:0]             head_idx,
    input  logic                      pop_rdy,
    output logic [DEPTH-1:0]          ent_vld,
    output logic [DEPTH-1:0][W-1:0]   ent_dat
);

    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_ptr;
    logic [CW-1:0]           cnt;
    logic                    full;
    logic                    push;
    logic                    pop;

    assign full     = (cnt == CW'(DEPTH));
    assign head_vld = (cnt != '0);
    assign head_idx = rd_ptr;
    assign pop      = head_vld && pop_rdy;
    assign push_rdy = !full || pop;
    assign push     = push_vld && push_rdy && !flush;
    assign ent_dat  = mem;

    always_comb begin
        logic [AW-1:0] off;
        off     = '0;
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = AW'(i) - rd_ptr;
            ent_vld[i] = (CW'(off) < cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fpu_wb_stage.sv
// FPU writeback stage: queues results, steers FP/INT register-file writes, reports pending FP dests.
// Latency 1 cycle from accept to write; only INT writes stall (on iwb_ready), which backpressures in_ready.
module fpu_wb_stage #(
    parameter int XLEN  = 32,
    parameter int OP_W  = 5,
    parameter int RA_W  = 5,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_result,
    input  logic [OP_W-1:0]       in_op,
    input  logic [RA_W-1:0]       in_rd,
    output logic                  fwb_we,
    output logic [RA_W-1:0]       fwb_addr,
    output logic [XLEN-1:0]       fwb_data,
    output logic                  iwb_we,
    output logic [RA_W-1:0]       iwb_addr,
    output logic [XLEN-1:0]       iwb_data,
    input  logic                  iwb_ready,
    output logic [(1<<RA_W)-1:0]  fp_pend,
    output logic                  err_illegal
);

    import fpu_pkg::*;

    localparam int AW = $clog2(DEPTH);

    // canon marks an arithmetic NaN; the canonical value is substituted on the way out.
    typedef struct packed {
        logic [XLEN-1:0] dat;
        logic            canon;
        op_cls_e         cls;
        logic [RA_W-1:0] rd;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t                in_ent;
    entry_t                head;
    entry_t [DEPTH-1:0]    ents;
    logic   [DEPTH-1:0]    ent_vld;
    logic                  head_vld;
    logic   [AW-1:0]       head_idx;
    logic                  deq;
    op_cls_e               in_cls;

    always_comb begin
        in_cls       = decode_cls(in_op);
        in_ent       = '0;
        in_ent.cls   = in_cls;
        in_ent.rd    = in_rd;
        in_ent.canon = (in_cls == CLS_FP) && needs_canon(in_op) && is_nan32(in_result[31:0]);
        if (in_cls == CLS_INT) begin
            in_ent.dat = {{(XLEN-1){1'b0}}, in_result[0]};
        end else begin
            in_ent.dat = in_result;
        end
    end

    fpu_wb_fifo #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (in_ent),
        .head_vld (head_vld),
        .head_idx (head_idx),
        .pop_rdy  (deq),
        .ent_vld  (ent_vld),
        .ent_dat  (ents)
    );

    assign head = ents[head_idx];

    // rd=0 INT results are architecturally discarded, so they never wait for the shared port.
    assign deq = head_vld && ((head.cls != CLS_INT) || (head.rd == '0) || iwb_ready);

    always_comb begin
        fwb_we      = 1'b0;
        fwb_addr    = '0;
        fwb_data    = '0;
        iwb_we      = 1'b0;
        iwb_addr    = '0;
        iwb_data    = '0;
        err_illegal = 1'b0;
        if (head_vld) begin
            case (head.cls)
                CLS_FP: begin
                    fwb_we   = 1'b1;
                    fwb_addr = head.rd;
                    fwb_data = head.canon ? XLEN'(CANON_NAN) : head.dat;
                end
                CLS_INT: begin
                    if (head.rd != '0) begin
                        iwb_we   = 1'b1;
                        iwb_addr = head.rd;
                        iwb_data = head.dat;
                    end
                end
                default: err_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        fp_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ents[i].cls == CLS_FP)) begin
                fp_pend[ents[i].rd] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_wb_stage.sv
// Randomized bench for fpu_wb_stage against a queue-level behavioural model.
module tb_fpu_wb_stage;

    localparam int DEPTH = 2;
    localparam int K_FP  = 0;
    localparam int K_INT = 1;
    localparam int K_ILL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic [4:0]  in_op = '0;
    logic [4:0]  in_rd = '0;
    logic        fwb_we;
    logic [4:0]  fwb_addr;
    logic [31:0] fwb_data;
    logic        iwb_we;
    logic [4:0]  iwb_addr;
    logic [31:0] iwb_data;
    logic        iwb_ready = 1'b0;
    logic [31:0] fp_pend;
    logic        err_illegal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] dat;
    } m_t;

    m_t mq[$];

    fpu_wb_stage #(.XLEN(32), .OP_W(5), .RA_W(5), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .fwb_we      (fwb_we),
        .fwb_addr    (fwb_addr),
        .fwb_data    (fwb_data),
        .iwb_we      (iwb_we),
        .iwb_addr    (iwb_addr),
        .iwb_data    (iwb_data),
        .iwb_ready   (iwb_ready),
        .fp_pend     (fp_pend),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic m_t model_entry(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] res);
        m_t e;
        e.rd = rd;
        if (op <= 5'd4) begin
            e.kind = K_FP;
            if (op <= 5'd2 && res[30:23] == 8'hFF && res[22:0] != 23'd0) e.dat = 32'h7FC0_0000;
            else e.dat = res;
        end else if (op <= 5'd7) begin
            e.kind = K_INT;
            e.dat  = {31'd0, res[0]};
        end else begin
            e.kind = K_ILL;
            e.dat  = '0;
        end
        return e;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_fwb_we"}, fwb_we, 0);
        check({tag, "_iwb_we"}, iwb_we, 0);
        check({tag, "_err"}, err_illegal, 0);
        check({tag, "_fp_pend"}, fp_pend, 0);
    endtask

    task automatic step(input logic v, input logic [4:0] op, input logic [4:0] rd,
                        input logic [31:0] res, input logic ir, input logic fl);
        m_t          h;
        logic        deq;
        logic        rdy;
        logic        e_fwe, e_iwe, e_err;
        logic [4:0]  e_fa, e_ia;
        logic [31:0] e_fd, e_id, p;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_rd     = rd;
        in_result = res;
        iwb_ready = ir;
        flush     = fl;
        #1;
        deq = 0; e_fwe = 0; e_iwe = 0; e_err = 0;
        e_fa = '0; e_ia = '0; e_fd = '0; e_id = '0;
        if (mq.size() > 0) begin
            h = mq[0];
            if (h.kind == K_FP) begin
                e_fwe = 1; e_fa = h.rd; e_fd = h.dat; deq = 1;
            end else if (h.kind == K_INT) begin
                if (h.rd != 0) begin
                    e_iwe = 1; e_ia = h.rd; e_id = h.dat;
                end
                deq = (h.rd == 0) || ir;
            end else begin
                e_err = 1; deq = 1;
            end
        end
        rdy = (mq.size() < DEPTH) || deq;
        p = '0;
        foreach (mq[i]) if (mq[i].kind == K_FP) p[mq[i].rd] = 1'b1;
        check("in_ready", in_ready, rdy);
        check("fwb_we", fwb_we, e_fwe);
        check("fwb_addr", fwb_addr, e_fa);
        check("fwb_data", fwb_data, e_fd);
        check("iwb_we", iwb_we, e_iwe);
        check("iwb_addr", iwb_addr, e_ia);
        check("iwb_data", iwb_data, e_id);
        check("err_illegal", err_illegal, e_err);
        check("fp_pend", fp_pend, p);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (deq) mq.delete(0);
            if (v && rdy) mq.push_back(model_entry(op, rd, res));
        end
    endtask

    task automatic idle(input int n, input logic ir);
        for (int i = 0; i < n; i++) step(0, 5'd0, 5'd0, 32'd0, ir, 0);
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  op, rd;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_fwb_addr", fwb_addr, 0);
        check("reset_fwb_data", fwb_data, 0);
        check("reset_iwb_addr", iwb_addr, 0);
        check("reset_iwb_data", iwb_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1);

        step(1, 5'd0, 5'd3, 32'hC060_0000, 1, 0);
        idle(2, 1);

        step(1, 5'd6, 5'd7, 32'h0000_0001, 0, 0);
        step(1, 5'd6, 5'd8, 32'h0000_0000, 0, 0);
        step(1, 5'd2, 5'd9, 32'h3F80_0000, 0, 0);
        step(1, 5'd0, 5'd10, 32'h4000_0000, 0, 0);
        step(1, 5'd0, 5'd10, 32'h4000_0000, 1, 0);
        idle(4, 1);

        step(1, 5'd2, 5'd2, 32'h7FA0_0001, 1, 0);
        step(1, 5'd4, 5'd2, 32'h7FA0_0001, 1, 0);
        step(1, 5'd1, 5'd0, 32'hFFC1_2345, 1, 0);
        idle(2, 1);

        step(1, 5'd5, 5'd0, 32'h0000_0001, 0, 0);
        step(1, 5'd9, 5'd4, 32'h1234_5678, 0, 0);
        idle(2, 0);

        step(1, 5'd6, 5'd5, 32'h0000_0001, 0, 0);
        step(1, 5'd0, 5'd6, 32'h0000_0000, 0, 0);
        step(1, 5'd0, 5'd11, 32'h4040_0000, 0, 1);
        idle(2, 1);

        step(1, 5'd7, 5'd12, 32'h0000_0001, 0, 0);
        step(1, 5'd1, 5'd13, 32'h0000_0001, 0, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        iwb_ready = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            r  = $urandom;
            if ($urandom_range(0, 3) == 0) r[30:23] = 8'hFF;
            step($urandom_range(0, 9) < 7, op, rd, r, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 49) == 0);
        end
        idle(4, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
